// File: rtl/osiris_imm_pkg.sv
// Shared immediate-type definitions for the ID-stage extension logic and the
// immediate packing unit.
//   imm_src_t       : 3-bit immediate type selector (101-111 are illegal)
//   I_TYPE..U_TYPE  : immediate type encodings
//   FIELD_W         : width of the instr[31:7] field
//   skid_state_t    : occupancy states of the packing unit's output buffer
package osiris_imm_pkg;

    localparam int INSTR_W = 32;
    localparam int FIELD_W = INSTR_W - 7;

    typedef logic [2:0] imm_src_t;

    localparam imm_src_t I_TYPE = 3'b000;
    localparam imm_src_t S_TYPE = 3'b001;
    localparam imm_src_t B_TYPE = 3'b010;
    localparam imm_src_t J_TYPE = 3'b011;
    localparam imm_src_t U_TYPE = 3'b100;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_pack_comb.sv
// Combinational immediate packer: scatters a 32-bit immediate into the
// instr[31:7] field for the given type, keeping all non-immediate bits from
// base_field, and flags immediates that are out of range or misaligned.
// Out-of-range immediates are still packed (truncated); only err is raised.
//   imm        : immediate to encode
//   imm_src    : immediate type
//   base_field : instr[31:7] skeleton (rd, rs1, rs2, funct3)
//   field      : packed instr[31:7]
//   err        : immediate not representable, or illegal type
import osiris_imm_pkg::*;

module imm_pack_comb #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] imm,
    input  imm_src_t         imm_src,
    input  logic [WIDTH-8:0] base_field,
    output logic [WIDTH-8:0] field,
    output logic             err
);

    // Range checks: the bits above the top encoded bit must be a pure sign
    // extension of it.
    logic sext_bad_11;
    logic sext_bad_12;
    logic sext_bad_20;

    assign sext_bad_11 = (imm[31:11] != '0) && (imm[31:11] != '1);
    assign sext_bad_12 = (imm[31:12] != '0) && (imm[31:12] != '1);
    assign sext_bad_20 = (imm[31:20] != '0) && (imm[31:20] != '1);

    always_comb begin
        field = base_field;
        err   = 1'b0;
        case (imm_src)
            I_TYPE: begin
                field[24:13] = imm[11:0];
                err          = sext_bad_11;
            end
            S_TYPE: begin
                field[24:18] = imm[11:5];
                field[4:0]   = imm[4:0];
                err          = sext_bad_11;
            end
            B_TYPE: begin
                field[24]    = imm[12];
                field[23:18] = imm[10:5];
                field[4:1]   = imm[4:1];
                field[0]     = imm[11];
                err          = sext_bad_12 | imm[0];
            end
            J_TYPE: begin
                field[24]    = imm[20];
                field[23:14] = imm[10:1];
                field[13]    = imm[11];
                field[12:5]  = imm[19:12];
                err          = sext_bad_20 | imm[0];
            end
            U_TYPE: begin
                field[24:5]  = imm[31:12];
                err          = (imm[11:0] != '0);
            end
            default: begin
                err          = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_pack_unit.sv
// Streaming immediate packing unit. Requests are packed combinationally and
// captured into a registered output stage backed by one skid entry, so the
// block keeps 1-cycle latency while absorbing one beat of consumer stall.
// Erroneous requests set a sticky flag and bump a saturating counter.
// Optional build macro IMM_PACK_ROUNDTRIP_CHECK_EN: unpacks the output entry
// with the ID-stage extension rules and flags any disagreement with the
// original immediate on o_rt_mismatch (plus an assertion).
//   i_clk, i_rst_n                  : clock, async active-low reset
//   i_valid/o_ready                 : request handshake (o_ready registered)
//   i_imm, i_imm_src, i_base_field  : request payload
//   o_valid/i_ready                 : result handshake
//   o_imm_field, o_err              : result payload
//   o_err_sticky, o_err_cnt         : error bookkeeping, cleared by i_clr_err
//   o_rt_mismatch                   : round-trip mismatch (optional build only)
//
// state      | meaning
// SKID_EMPTY | output stage empty, o_valid=0
// SKID_ONE   | output stage holds an entry, skid entry empty
// SKID_TWO   | both entries full, o_ready=0
import osiris_imm_pkg::*;

module imm_pack_unit #(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_imm,
    input  logic [2:0]           i_imm_src,
    input  logic [WIDTH-8:0]     i_base_field,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-8:0]     o_imm_field,
    output logic                 o_err,
    output logic                 o_err_sticky,
    input  logic                 i_clr_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
`ifdef IMM_PACK_ROUNDTRIP_CHECK_EN
    ,
    output logic                 o_rt_mismatch
`endif
);

    skid_state_t          state_q, state_d;
    logic                 ready_q;
    logic [WIDTH-8:0]     out_field_q, skid_field_q;
    logic                 out_err_q, skid_err_q;
    logic [WIDTH-8:0]     new_field;
    logic                 new_err;
    logic                 accept, drain;
    logic                 load_out_new, load_out_skid, load_skid;
    logic                 err_sticky_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    imm_pack_comb #(.WIDTH(WIDTH)) u_pack (
        .imm        (i_imm),
        .imm_src    (i_imm_src),
        .base_field (i_base_field),
        .field      (new_field),
        .err        (new_err)
    );

    assign accept = i_valid & ready_q;
    assign drain  = (state_q != SKID_EMPTY) & i_ready;

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    load_out_new = 1'b1;
                    state_d      = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    load_skid    = 1'b1;
                    state_d      = SKID_TWO;
                end else if (drain) begin
                    state_d      = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (drain) begin
                    load_out_skid = 1'b1;
                    state_d       = SKID_ONE;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != SKID_TWO);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_field_q  <= '0;
            out_err_q    <= 1'b0;
            skid_field_q <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            if (load_out_new) begin
                out_field_q <= new_field;
                out_err_q   <= new_err;
            end else if (load_out_skid) begin
                out_field_q <= skid_field_q;
                out_err_q   <= skid_err_q;
            end
            if (load_skid) begin
                skid_field_q <= new_field;
                skid_err_q   <= new_err;
            end
        end
    end

    // Clear has priority over a same-cycle erroneous accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else if (i_clr_err) begin
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else if (accept && new_err) begin
            err_sticky_q <= 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = (state_q != SKID_EMPTY);
    assign o_imm_field  = out_field_q;
    assign o_err        = out_err_q;
    assign o_err_sticky = err_sticky_q;
    assign o_err_cnt    = err_cnt_q;

`ifdef IMM_PACK_ROUNDTRIP_CHECK_EN
    logic [WIDTH-1:0] out_imm_q, skid_imm_q;
    imm_src_t         out_src_q, skid_src_q;
    logic [WIDTH-1:0] rt_imm;
    logic             rt_bad;
    logic             rt_mismatch_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_imm_q  <= '0;
            out_src_q  <= I_TYPE;
            skid_imm_q <= '0;
            skid_src_q <= I_TYPE;
        end else begin
            if (load_out_new) begin
                out_imm_q <= i_imm;
                out_src_q <= i_imm_src;
            end else if (load_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_src_q <= skid_src_q;
            end
            if (load_skid) begin
                skid_imm_q <= i_imm;
                skid_src_q <= i_imm_src;
            end
        end
    end

    // Same reconstruction the ID stage performs on the finished instruction.
    always_comb begin
        rt_imm = '0;
        case (out_src_q)
            I_TYPE: rt_imm = {{(WIDTH-12){out_field_q[24]}}, out_field_q[24:13]};
            S_TYPE: rt_imm = {{(WIDTH-12){out_field_q[24]}}, out_field_q[24:18],
                              out_field_q[4:0]};
            B_TYPE: rt_imm = {{(WIDTH-13){out_field_q[24]}}, out_field_q[24],
                              out_field_q[0], out_field_q[23:18], out_field_q[4:1], 1'b0};
            J_TYPE: rt_imm = {{(WIDTH-21){out_field_q[24]}}, out_field_q[24],
                              out_field_q[12:5], out_field_q[13], out_field_q[23:14], 1'b0};
            U_TYPE: rt_imm = {out_field_q[24:5], 12'b0};
            default: rt_imm = out_imm_q;
        endcase
    end

    assign rt_bad = o_valid && !out_err_q && (rt_imm != out_imm_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rt_mismatch_q <= 1'b0;
        end else if (i_clr_err) begin
            rt_mismatch_q <= 1'b0;
        end else if (rt_bad) begin
            rt_mismatch_q <= 1'b1;
        end
    end

    assign o_rt_mismatch = rt_mismatch_q;

    a_roundtrip: assert property (@(posedge i_clk) disable iff (!i_rst_n) !rt_bad);
`endif

endmodule

// File: tb/tb_imm_pack_unit.sv
module tb_imm_pack_unit;

    localparam int WIDTH     = 32;
    localparam int FW        = WIDTH - 7;
    localparam int ERR_CNT_W = 4;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_imm;
    logic [2:0]           i_imm_src;
    logic [FW-1:0]        i_base_field;
    logic                 o_valid;
    logic                 i_ready;
    logic [FW-1:0]        o_imm_field;
    logic                 o_err;
    logic                 o_err_sticky;
    logic                 i_clr_err;
    logic [ERR_CNT_W-1:0] o_err_cnt;
`ifdef IMM_PACK_ROUNDTRIP_CHECK_EN
    logic                 o_rt_mismatch;
`endif

    imm_pack_unit #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_imm        (i_imm),
        .i_imm_src    (i_imm_src),
        .i_base_field (i_base_field),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_imm_field  (o_imm_field),
        .o_err        (o_err),
        .o_err_sticky (o_err_sticky),
        .i_clr_err    (i_clr_err),
        .o_err_cnt    (o_err_cnt)
`ifdef IMM_PACK_ROUNDTRIP_CHECK_EN
        ,
        .o_rt_mismatch(o_rt_mismatch)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_miscmp = 0;

    // Reference state: FIFO of expected outputs plus error bookkeeping.
    logic [FW-1:0] q_field[$];
    logic          q_err[$];
    logic          m_sticky;
    int            m_cnt;
    logic          last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Packing expressed on the full instruction word, error by numeric range.
    function automatic void ref_pack(input logic [31:0] imm, input logic [2:0] src,
                                     input logic [FW-1:0] base,
                                     output logic [FW-1:0] f, output logic e);
        logic [31:0] ins;
        int s;
        s   = int'(signed'(imm));
        ins = {base, 7'b0};
        e   = 1'b0;
        case (src)
            3'd0: begin
                ins[31:20] = imm[11:0];
                e = !(s >= -2048 && s <= 2047);
            end
            3'd1: begin
                ins[31:25] = imm[11:5];
                ins[11:7]  = imm[4:0];
                e = !(s >= -2048 && s <= 2047);
            end
            3'd2: begin
                ins[31]    = imm[12];
                ins[30:25] = imm[10:5];
                ins[11:8]  = imm[4:1];
                ins[7]     = imm[11];
                e = !(s >= -4096 && s <= 4095) || (s % 2 != 0);
            end
            3'd3: begin
                ins[31]    = imm[20];
                ins[30:21] = imm[10:1];
                ins[20]    = imm[11];
                ins[19:12] = imm[19:12];
                e = !(s >= -(1 << 20) && s <= (1 << 20) - 1) || (s % 2 != 0);
            end
            3'd4: begin
                ins[31:12] = imm[31:12];
                e = (imm % 32'd4096) != 0;
            end
            default: e = 1'b1;
        endcase
        f = ins[31:7];
    endfunction

    // One clock: compare at the negedge, advance the model, step to posedge+1.
    task automatic cycle();
        int n;
        logic acc, drn;
        logic [FW-1:0] f;
        logic e;
        @(negedge i_clk);
        n = q_field.size();
        check("valid", o_valid, n != 0);
        check("ready", o_ready, n < 2);
        check("sticky", o_err_sticky, m_sticky);
        check("cnt", o_err_cnt, m_cnt);
        if (n != 0) begin
            check("field", o_imm_field, q_field[0]);
            check("err", o_err, q_err[0]);
        end
        drn = (n != 0) && i_ready;
        acc = i_valid && (n < 2);
        ref_pack(i_imm, i_imm_src, i_base_field, f, e);
        if (drn) begin
            void'(q_field.pop_front());
            void'(q_err.pop_front());
        end
        if (acc) begin
            q_field.push_back(f);
            q_err.push_back(e);
        end
        if (i_clr_err) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
        end else if (acc && e) begin
            m_sticky = 1'b1;
            if (m_cnt < (1 << ERR_CNT_W) - 1) m_cnt++;
        end
        last_acc = acc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic put(input logic [31:0] imm, input logic [2:0] src, input logic [FW-1:0] base);
        i_valid      = 1'b1;
        i_imm        = imm;
        i_imm_src    = src;
        i_base_field = base;
        cycle();
        i_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = ($urandom_range(0, 1) != 0) ? (32'hFFFF_F800 | ($urandom & 32'h7FF))
                                                : ($urandom & 32'h7FF);
            2: v = $urandom & 32'hFFFF_F000;
            default: v = (($urandom_range(0, 1) != 0) ? 32'hFFF0_0000 : 32'h0)
                         | ($urandom & 32'h000F_FFFE);
        endcase
        return v;
    endfunction

    initial begin
        i_rst_n      = 1'b0;
        i_valid      = 1'b0;
        i_ready      = 1'b1;
        i_imm        = '0;
        i_imm_src    = 3'd0;
        i_base_field = '0;
        i_clr_err    = 1'b0;
        m_sticky     = 1'b0;
        m_cnt        = 0;
        last_acc     = 1'b0;
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_field", o_imm_field, 0);
        check("rst_err", o_err, 0);
        check("rst_sticky", o_err_sticky, 0);
        check("rst_cnt", o_err_cnt, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed vectors
        put(32'hFFFF_F800, 3'd0, '0);
        cycle();
        put(32'h0000_0800, 3'd0, '0);
        cycle();
        i_clr_err = 1'b1;
        cycle();
        i_clr_err = 1'b0;
        cycle();
        put(32'hFFFF_FFFE, 3'd2, '0);
        put(32'h0000_0003, 3'd2, '0);
        put(32'h1234_5000, 3'd4, 25'h00001F);
        put(32'h1234_5001, 3'd4, 25'h00001F);
        put(32'h0000_0010, 3'd1, 25'h1ABCDEF);
        put(32'h000F_FFFE, 3'd3, 25'h0123456);
        put(32'h0010_0000, 3'd3, 25'h0);
        put(32'h0000_0004, 3'd5, 25'h155AA55);
        put(32'h0000_0004, 3'd7, 25'h0AA55AA);
        cycle();

        // Clear wins over a same-cycle erroneous accept
        i_clr_err = 1'b1;
        put(32'h8000_0000, 3'd1, '0);
        i_clr_err = 1'b0;
        cycle();

        // Stall: A and B accepted, C held until space opens
        i_ready = 1'b0;
        put(32'h0000_0123, 3'd0, 25'h0000011);
        put(32'h0000_0456, 3'd1, 25'h0000022);
        put(32'h0000_0100, 3'd2, 25'h0000033);
        check("c_held_off", last_acc, 0);
        i_valid = 1'b1;
        cycle();
        i_ready = 1'b1;
        last_acc = 1'b0;
        for (int k = 0; k < 6 && !last_acc; k++) cycle();
        check("c_accepted", last_acc, 1);
        i_valid = 1'b0;
        repeat (3) cycle();

        // Counter saturation
        for (int k = 0; k < 20; k++) put(32'h0000_0001, 3'd4, '0);
        cycle();

        // Asynchronous reset while both entries are full
        i_ready = 1'b0;
        put(32'h0000_0001, 3'd0, '0);
        put(32'h0001_0000, 3'd0, '0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_ready", o_ready, 1);
        check("arst_cnt", o_err_cnt, 0);
        check("arst_sticky", o_err_sticky, 0);
        q_field.delete();
        q_err.delete();
        m_sticky = 1'b0;
        m_cnt    = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        put(32'hFFFF_FFF0, 3'd1, 25'h0F0F0F0);
        cycle();

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            i_valid      = ($urandom_range(0, 3) != 0);
            i_ready      = ($urandom_range(0, 2) != 0);
            i_clr_err    = ($urandom_range(0, 40) == 0);
            i_imm        = rand_imm();
            i_imm_src    = 3'($urandom_range(0, 7) < 6 ? $urandom_range(0, 4) : $urandom_range(5, 7));
            i_base_field = FW'($urandom);
            cycle();
        end
        i_valid   = 1'b0;
        i_clr_err = 1'b0;
        i_ready   = 1'b1;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/imm_pack_unit.md
Name: imm_pack_unit

Overview:
- Inverse of the ID-stage immediate extension: takes a 32-bit immediate plus an immediate type and packs it into the instruction's bits [31:7] field, merging in the non-immediate bits from a base field.
- Checks that the immediate is representable for its type (range and alignment) and flags errors.
- Used by the debug instruction-injection path and the self-test instruction generator.
- Streaming block: valid/ready input, registered output, 2-entry skid buffer, sticky error and saturating error counter.

Parameters:
- WIDTH, 32, instruction/immediate width; packed field is WIDTH-7 bits.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request; registered.
- i_imm  input  WIDTH  immediate value to encode.
- i_imm_src  input  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U; 101-111 illegal.
- i_base_field  input  WIDTH-7  instr[31:7] skeleton supplying the non-immediate bits (rd, rs1, rs2, funct3).
- o_valid  output  1  packed result valid.
- i_ready  input  1  consumer accepts the result.
- o_imm_field  output  WIDTH-7  packed instr[31:7].
- o_err  output  1  error flag of the current output entry.
- o_err_sticky  output  1  set by any accepted erroneous request.
- i_clr_err  input  1  synchronous clear of o_err_sticky and o_err_cnt.
- o_err_cnt  output  ERR_CNT_W  saturating count of erroneous requests.

Behaviour:
- Reset: o_valid=0, o_ready=1, o_imm_field=0, o_err=0, o_err_sticky=0, o_err_cnt=0, both skid entries invalid.
- Packing is combinational. Field index f = instr bit minus 7. Bits not listed are taken from i_base_field.
  - I: f[24:13]=imm[11:0].
  - S: f[24:18]=imm[11:5]; f[4:0]=imm[4:0].
  - B: f[24]=imm[12]; f[23:18]=imm[10:5]; f[4:1]=imm[4:1]; f[0]=imm[11].
  - J: f[24]=imm[20]; f[23:14]=imm[10:1]; f[13]=imm[11]; f[12:5]=imm[19:12].
  - U: f[24:5]=imm[31:12].
- Error conditions:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - Illegal src: error, and the field equals i_base_field unchanged.
  - On error the truncated bits are still packed; the error is only flagged.
- Handshake:
  - A transfer occurs when valid and ready are both high at the clock edge.
  - Latency is 1 cycle: a request accepted at edge N shows o_valid=1 after edge N.
  - o_valid and the output data hold stable while i_ready=0.
  - Order is preserved.
- Skid buffer FSM:
  - EMPTY: on accept, go to ONE.
  - ONE: accept without drain goes to TWO; drain without accept goes to EMPTY; simultaneous accept and drain stays in ONE with the output replaced by the new entry.
  - TWO: o_ready=0; a drain moves the skid entry to the output and goes to ONE.
  - o_ready = (state != TWO), registered.
- Error bookkeeping:
  - On an accepted erroneous request: o_err_sticky <= 1 and o_err_cnt increments, saturating at all ones.
  - i_clr_err in the same cycle as an erroneous accept: the clear wins (result is 0).
- Asynchronous reset at any time, including mid-stream or in TWO, returns everything to reset values immediately; buffered entries are discarded.

Optional Feature:
- Macro: IMM_PACK_ROUNDTRIP_CHECK_EN.
- When defined:
  - The output entry is unpacked with the ID-stage sign-extension rules and compared against the stored original immediate.
  - For non-error entries with o_valid=1, a mismatch raises o_rt_mismatch (extra 1-bit output, reset 0, sticky until i_clr_err) and fires an assertion.
  - Adds one stored WIDTH-bit immediate per skid entry.
- When undefined: none of this logic exists and there is no o_rt_mismatch port.

Decomposition:
- Package osiris_imm_pkg holds:
  - the 3-bit imm_src encodings I_type through U_type, shared with the ID-stage extension logic;
  - a typedef for imm_src;
  - the field width constant.
- One sub-module, imm_pack_comb: purely combinational packing plus the range/alignment check, producing field and err. The top module holds the skid FSM and counters.

Test Plan:
- I, imm=32'hFFFF_F800, base=0, i_ready=1 -> one cycle later o_imm_field=25'h1000000, o_err=0.
- I, imm=32'h0000_0800 -> o_err=1, o_err_sticky=1, o_err_cnt=1; then i_clr_err -> both return to 0.
- B, imm=32'hFFFF_FFFE, base=0 -> o_imm_field=25'h1FC001F, o_err=0. Then imm=32'h0000_0003 -> o_err=1 (misaligned).
- U, imm=32'h1234_5000, base=25'h00001F -> o_imm_field=25'h2468BF, o_err=0. Then imm=32'h1234_5001 -> o_err=1.
- Hold i_ready=0 and drive 3 back-to-back requests A, B, C -> A and B accepted, o_ready=0 from the cycle after B, output holds A. Release i_ready -> order A, B, C, with C accepted once o_ready returns to 1.
- In TWO state, pulse i_rst_n low mid-cycle -> o_valid=0, o_ready=1, o_err_cnt=0 immediately; a new request after reset is accepted normally.
